// File: rtl/isa_pkg.sv
// Shared ISA definitions for the decode stage: the field layout of an
// instruction word, opcode names, the two-word (long) opcode set and the
// short-immediate opcode range.
package isa_pkg;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS_MSB  = 7;
  localparam int RS_LSB  = 4;
  localparam int RT_MSB  = 3;
  localparam int RT_LSB  = 0;
  localparam int SIMM_W  = 8;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_ADD  = 4'h1, OP_SUB  = 4'h2, OP_AND  = 4'h3,
    OP_OR   = 4'h4, OP_XOR  = 4'h5, OP_SHL  = 4'h6, OP_SHR  = 4'h7,
    OP_ADDI = 4'h8, OP_LDI  = 4'h9, OP_LD   = 4'hA, OP_ST   = 4'hB,
    OP_BEQ  = 4'hC, OP_BNE  = 4'hD, OP_JMP  = 4'hE, OP_CALL = 4'hF
  } opcode_t;

  typedef enum logic {
    S_FIRST = 1'b0,
    S_EXT   = 1'b1
  } dstate_t;

  // Long opcodes carry a full-width immediate in a second word.
  localparam opcode_t LONG_OP_A = OP_JMP;
  localparam opcode_t LONG_OP_B = OP_CALL;

  // Short-immediate opcodes embed an 8-bit signed immediate in rs/rt.
  localparam opcode_t SHORT_IMM_LO = OP_ADDI;
  localparam opcode_t SHORT_IMM_HI = OP_ST;

  function automatic logic is_long_op(input opcode_t op);
    return (op == LONG_OP_A) || (op == LONG_OP_B);
  endfunction

  function automatic logic is_short_imm_op(input opcode_t op);
    return (op >= SHORT_IMM_LO) && (op <= SHORT_IMM_HI);
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Fetch -> decode -> execute signal bundle for the decode stage.
// master: the fetch/hazard side driving words and control.
// slave:  the decode stage itself.
interface id_stage_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) ();
  logic [DATA_W-1:0] instr_in;
  logic              instr_valid;
  logic              stall;
  logic              flush;
  logic              pc_hold;
  logic              id_valid;
  logic [3:0]        opcode;
  logic [3:0]        rd;
  logic [3:0]        rs;
  logic [3:0]        rt;
  logic [DATA_W-1:0] imm;
  logic              has_imm;
  logic [CNT_W-1:0]  dec_count;

  modport master (
    output instr_in, instr_valid, stall, flush,
    input  pc_hold, id_valid, opcode, rd, rs, rt, imm, has_imm, dec_count
  );

  modport slave (
    input  instr_in, instr_valid, stall, flush,
    output pc_hold, id_valid, opcode, rd, rs, rt, imm, has_imm, dec_count
  );
endinterface

// File: rtl/id_field_decode.sv
// Pure combinational split of one instruction word into its fields,
// plus the long-opcode flag and the sign-extended short immediate.
module id_field_decode
  import isa_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] word_i,
  output opcode_t           opcode_o,
  output logic [3:0]        rd_o,
  output logic [3:0]        rs_o,
  output logic [3:0]        rt_o,
  output logic              is_long_o,
  output logic              short_imm_en_o,
  output logic [DATA_W-1:0] short_imm_o
);

  assign opcode_o       = opcode_t'(word_i[OPC_MSB:OPC_LSB]);
  assign rd_o           = word_i[RD_MSB:RD_LSB];
  assign rs_o           = word_i[RS_MSB:RS_LSB];
  assign rt_o           = word_i[RT_MSB:RT_LSB];
  assign is_long_o      = is_long_op(opcode_o);
  assign short_imm_en_o = is_short_imm_op(opcode_o);
  assign short_imm_o    = {{(DATA_W-SIMM_W){word_i[SIMM_W-1]}}, word_i[SIMM_W-1:0]};

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage. Assembles one- or two-word instructions from
// the fetch stream, registers the decoded fields for execute, freezes on
// stall, discards a half-assembled instruction on flush and counts
// completed decodes.
//
//  state   | meaning
//  S_FIRST | next accepted word starts a new instruction
//  S_EXT   | first word of a long op is in hold_q, waiting for its immediate
module id_stage
  import isa_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic clock,
  input  logic reset_n,
  id_stage_if.slave bus
);

  dstate_t           state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              id_valid_q, id_valid_d;
  logic [3:0]        opcode_q, opcode_d;
  logic [3:0]        rd_q, rd_d;
  logic [3:0]        rs_q, rs_d;
  logic [3:0]        rt_q, rt_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              has_imm_q, has_imm_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // In S_EXT the fields come from the held first word; otherwise from the
  // live word. Sharing one decoder keeps the field layout in one place.
  logic [DATA_W-1:0] dec_word;
  opcode_t           dec_opcode;
  logic [3:0]        dec_rd, dec_rs, dec_rt;
  logic              dec_is_long, dec_simm_en;
  logic [DATA_W-1:0] dec_simm;

  assign dec_word = (state_q == S_EXT) ? hold_q : bus.instr_in;

  id_field_decode #(.DATA_W(DATA_W)) u_dec (
    .word_i         (dec_word),
    .opcode_o       (dec_opcode),
    .rd_o           (dec_rd),
    .rs_o           (dec_rs),
    .rt_o           (dec_rt),
    .is_long_o      (dec_is_long),
    .short_imm_en_o (dec_simm_en),
    .short_imm_o    (dec_simm)
  );

  // Next-state and output-register logic; flush beats stall beats normal.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    id_valid_d = id_valid_q;
    opcode_d   = opcode_q;
    rd_d       = rd_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    imm_d      = imm_q;
    has_imm_d  = has_imm_q;
    cnt_d      = cnt_q;

    if (bus.flush) begin
      state_d    = S_FIRST;
      hold_d     = '0;
      id_valid_d = 1'b0;
    end else if (bus.stall) begin
      // everything holds
    end else if (bus.instr_valid) begin
      unique case (state_q)
        S_FIRST: begin
          if (dec_is_long) begin
            hold_d     = bus.instr_in;
            state_d    = S_EXT;
            id_valid_d = 1'b0;
          end else begin
            opcode_d   = dec_opcode;
            rd_d       = dec_rd;
            rs_d       = dec_rs;
            rt_d       = dec_rt;
            imm_d      = dec_simm_en ? dec_simm : '0;
            has_imm_d  = dec_simm_en;
            id_valid_d = 1'b1;
            cnt_d      = cnt_q + 1'b1;
          end
        end
        S_EXT: begin
          opcode_d   = dec_opcode;
          rd_d       = dec_rd;
          rs_d       = dec_rs;
          rt_d       = dec_rt;
          imm_d      = bus.instr_in;
          has_imm_d  = 1'b1;
          id_valid_d = 1'b1;
          cnt_d      = cnt_q + 1'b1;
          state_d    = S_FIRST;
        end
        default: state_d = S_FIRST;
      endcase
    end else begin
      id_valid_d = 1'b0;
    end
  end

  // State, hold and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_FIRST;
      hold_q     <= '0;
      id_valid_q <= 1'b0;
      opcode_q   <= '0;
      rd_q       <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      imm_q      <= '0;
      has_imm_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      id_valid_q <= id_valid_d;
      opcode_q   <= opcode_d;
      rd_q       <= rd_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      imm_q      <= imm_d;
      has_imm_q  <= has_imm_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.pc_hold   = bus.stall;
  assign bus.id_valid  = id_valid_q;
  assign bus.opcode    = opcode_q;
  assign bus.rd        = rd_q;
  assign bus.rs        = rs_q;
  assign bus.rt        = rt_q;
  assign bus.imm       = imm_q;
  assign bus.has_imm   = has_imm_q;
  assign bus.dec_count = cnt_q;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_id_stage;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;

  logic clock;
  logic reset_n;
  int   n_cmp;
  int   n_bad;
  bit   check_en;

  id_stage_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  id_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural model: a pending first word plus the expected outputs.
  bit        m_pend;
  logic [15:0] m_pword;
  bit        e_valid;
  logic [3:0] e_op, e_rd, e_rs, e_rt;
  logic [15:0] e_imm;
  bit        e_has;
  int        e_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock or negedge reset_n) begin
    logic [15:0] w;
    logic [15:0] src;
    if (!reset_n) begin
      m_pend = 0; m_pword = '0; e_valid = 0; e_op = '0; e_rd = '0; e_rs = '0;
      e_rt = '0; e_imm = '0; e_has = 0; e_cnt = 0;
    end else if (bus.flush) begin
      m_pend = 0;
      e_valid = 0;
    end else if (bus.stall) begin
      // frozen
    end else if (bus.instr_valid) begin
      w = bus.instr_in;
      if (m_pend) begin
        src = m_pword;
        e_op = src[15:12]; e_rd = src[11:8]; e_rs = src[7:4]; e_rt = src[3:0];
        e_imm = w; e_has = 1; e_valid = 1; m_pend = 0;
        e_cnt = (e_cnt + 1) % (1 << CNT_W);
      end else if (w[15:12] == 4'hE || w[15:12] == 4'hF) begin
        m_pend = 1; m_pword = w; e_valid = 0;
      end else begin
        e_op = w[15:12]; e_rd = w[11:8]; e_rs = w[7:4]; e_rt = w[3:0];
        if (w[15:12] >= 4'h8 && w[15:12] <= 4'hB) begin
          e_imm = 16'($signed(w[7:0]));
          e_has = 1;
        end else begin
          e_imm = 0;
          e_has = 0;
        end
        e_valid = 1;
        e_cnt = (e_cnt + 1) % (1 << CNT_W);
      end
    end else begin
      e_valid = 0;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clock) begin
    if (check_en) begin
      chk("id_valid", 32'(bus.id_valid), 32'(e_valid));
      chk("dec_count", 32'(bus.dec_count), 32'(e_cnt));
      chk("pc_hold", 32'(bus.pc_hold), 32'(bus.stall));
      if (e_valid) begin
        chk("opcode", 32'(bus.opcode), 32'(e_op));
        chk("rd", 32'(bus.rd), 32'(e_rd));
        chk("rs", 32'(bus.rs), 32'(e_rs));
        chk("rt", 32'(bus.rt), 32'(e_rt));
        chk("imm", 32'(bus.imm), 32'(e_imm));
        chk("has_imm", 32'(bus.has_imm), 32'(e_has));
      end
      if (!reset_n) begin
        chk("rst_opcode", 32'(bus.opcode), 32'h0);
        chk("rst_rd", 32'(bus.rd), 32'h0);
        chk("rst_rs", 32'(bus.rs), 32'h0);
        chk("rst_rt", 32'(bus.rt), 32'h0);
        chk("rst_imm", 32'(bus.imm), 32'h0);
        chk("rst_has_imm", 32'(bus.has_imm), 32'h0);
      end
    end
  end

  // Drive one cycle of inputs shortly after a falling edge, return at the next one.
  task automatic drive(input bit v, input logic [15:0] w, input bit s, input bit f);
    #2;
    bus.instr_valid = v;
    bus.instr_in    = w;
    bus.stall       = s;
    bus.flush       = f;
    @(negedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rw;
    n_cmp = 0; n_bad = 0; check_en = 0;
    reset_n = 1'b0;
    bus.instr_valid = 0; bus.instr_in = '0; bus.stall = 0; bus.flush = 0;
    @(negedge clock); check_en = 1;
    @(negedge clock);
    chk("lit_reset_valid", 32'(bus.id_valid), 32'h0);
    chk("lit_reset_count", 32'(bus.dec_count), 32'h0);
    #2 reset_n = 1'b1;

    // single-word decode
    drive(1, 16'h1234, 0, 0);
    chk("lit1_valid", 32'(bus.id_valid), 32'h1);
    chk("lit1_op", 32'(bus.opcode), 32'h1);
    chk("lit1_rd", 32'(bus.rd), 32'h2);
    chk("lit1_rs", 32'(bus.rs), 32'h3);
    chk("lit1_rt", 32'(bus.rt), 32'h4);
    chk("lit1_has", 32'(bus.has_imm), 32'h0);
    chk("lit1_cnt", 32'(bus.dec_count), 32'h1);

    // short immediates
    drive(1, 16'h8AFF, 0, 0);
    chk("lit2_imm", 32'(bus.imm), 32'hFFFF);
    chk("lit2_has", 32'(bus.has_imm), 32'h1);
    chk("lit2_rd", 32'(bus.rd), 32'hA);
    drive(1, 16'h9A7F, 0, 0);
    chk("lit2b_imm", 32'(bus.imm), 32'h007F);

    // long instruction, back to back
    drive(1, 16'hE500, 0, 0);
    chk("lit3_bubble", 32'(bus.id_valid), 32'h0);
    drive(1, 16'hBEEF, 0, 0);
    chk("lit3_valid", 32'(bus.id_valid), 32'h1);
    chk("lit3_op", 32'(bus.opcode), 32'hE);
    chk("lit3_rd", 32'(bus.rd), 32'h5);
    chk("lit3_imm", 32'(bus.imm), 32'hBEEF);
    chk("lit3_has", 32'(bus.has_imm), 32'h1);

    // long instruction with idle gap
    drive(1, 16'hF100, 0, 0);
    chk("lit4_b0", 32'(bus.id_valid), 32'h0);
    drive(0, 16'h0000, 0, 0);
    chk("lit4_b1", 32'(bus.id_valid), 32'h0);
    drive(0, 16'h0000, 0, 0);
    chk("lit4_b2", 32'(bus.id_valid), 32'h0);
    drive(1, 16'h0042, 0, 0);
    chk("lit4_imm", 32'(bus.imm), 32'h0042);
    chk("lit4_op", 32'(bus.opcode), 32'hF);
    chk("lit4_cnt", 32'(bus.dec_count), 32'h5);

    // stall freezes, flush beats stall
    drive(1, 16'h1234, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom_range(0, 1)), 16'($urandom), 1, 0);
      chk("lit5_valid", 32'(bus.id_valid), 32'h1);
      chk("lit5_cnt", 32'(bus.dec_count), 32'h6);
      chk("lit5_op", 32'(bus.opcode), 32'h1);
      chk("lit5_pchold", 32'(bus.pc_hold), 32'h1);
    end
    drive(1, 16'h2222, 1, 1);
    chk("lit5_flush", 32'(bus.id_valid), 32'h0);
    chk("lit5_fcnt", 32'(bus.dec_count), 32'h6);
    drive(0, 16'h0000, 0, 0);
    chk("lit5_pcrel", 32'(bus.pc_hold), 32'h0);

    // flush drops held first word
    drive(1, 16'hE000, 0, 0);
    drive(1, 16'h1111, 0, 1);
    chk("lit6_flush", 32'(bus.id_valid), 32'h0);
    drive(1, 16'h1111, 0, 0);
    chk("lit6_op", 32'(bus.opcode), 32'h1);
    chk("lit6_imm", 32'(bus.imm), 32'h0000);
    chk("lit6_has", 32'(bus.has_imm), 32'h0);

    // reset while waiting for an extension word
    drive(1, 16'hE000, 0, 0);
    #2 reset_n = 1'b0; bus.instr_valid = 0;
    @(negedge clock);
    chk("lit6_rst_valid", 32'(bus.id_valid), 32'h0);
    chk("lit6_rst_cnt", 32'(bus.dec_count), 32'h0);
    chk("lit6_rst_op", 32'(bus.opcode), 32'h0);
    #2 reset_n = 1'b1;
    drive(1, 16'h1234, 0, 0);
    chk("lit6_first", 32'(bus.id_valid), 32'h1);
    chk("lit6_first_op", 32'(bus.opcode), 32'h1);

    // counter wrap: 17 loads since reset on a 4-bit counter
    for (int i = 0; i < 16; i++) begin
      rw = 16'($urandom);
      rw[15] = 1'b0;
      drive(1, rw, 0, 0);
    end
    chk("lit_wrap", 32'(bus.dec_count), 32'h1);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        #2 reset_n = 1'b0;
        @(negedge clock);
        #2 reset_n = 1'b1;
      end
      drive(($urandom_range(0, 99) < 70), 16'($urandom),
            ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 8));
    end

    check_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
